// File: rtl/vga_timing_gen.sv
// Free-running VGA raster generator: pixel/line counters with registered
// sync/blank decodes, a frame-start strobe and a completed-frame counter.
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_BLNK   = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_BLNK   = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] h_nxt, v_nxt;
  logic        wrap;

  always_comb begin
    h_nxt = hcount_out + 11'd1;
    v_nxt = vcount_out;
    wrap  = 1'b0;
    if (hcount_out == H_LAST) begin
      h_nxt = '0;
      if (vcount_out == V_LAST) begin
        v_nxt = '0;
        wrap  = 1'b1;
      end else begin
        v_nxt = vcount_out + 11'd1;
      end
    end
  end

  // Decodes are taken from the next-state counts so every output of one
  // register stage describes the same pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount_out  <= '0;
      vcount_out  <= '0;
      hsync_out   <= 1'b0;
      hblnk_out   <= 1'b0;
      vsync_out   <= 1'b0;
      vblnk_out   <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_start <= 1'b0;
      if (en) begin
        hcount_out  <= h_nxt;
        vcount_out  <= v_nxt;
        hblnk_out   <= (h_nxt >= H_BLNK);
        hsync_out   <= (h_nxt >= HS_BEG) && (h_nxt < HS_END);
        vblnk_out   <= (v_nxt >= V_BLNK);
        vsync_out   <= (v_nxt >= VS_BEG) && (v_nxt < VS_END);
        frame_start <= wrap;
        if (wrap) frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster so whole frames fit in a
// short run; a per-cycle scoreboard plus feature-specific inline checks.
module tb_vga_timing_gen;

  localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
  localparam int VA = 8,  VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;  // 25
  localparam int VT = VA + VFP + VS + VBP;  // 13

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs, hb, vs, vb, fs;
    logic [15:0] fc;
  } exp_t;

  logic        clk, rst, en;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out, frame_start;
  logic [15:0] frame_cnt;
  exp_t        obs;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];

  int          m_h, m_v;
  logic [15:0] m_fc;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .hblnk_out(hblnk_out),
    .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  assign obs = {hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out,
                vblnk_out, frame_start, frame_cnt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard: one expected entry per driven clock, checked just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL scoreboard: got h=%0d v=%0d hs=%b hb=%b vs=%b vb=%b fs=%b fc=%0d want h=%0d v=%0d hs=%b hb=%b vs=%b vb=%b fs=%b fc=%0d",
                 obs.h, obs.v, obs.hs, obs.hb, obs.vs, obs.vb, obs.fs, obs.fc,
                 e.h, e.v, e.hs, e.hb, e.vs, e.vb, e.fs, e.fc);
      end
    end
  end

  function automatic exp_t model_out(input logic fs);
    exp_t e;
    e.h  = 11'(m_h);
    e.v  = 11'(m_v);
    e.hb = (m_h >= 16);
    e.hs = (m_h >= 18) && (m_h <= 21);
    e.vb = (m_v >= 8);
    e.vs = (m_v >= 9) && (m_v <= 10);
    e.fs = fs;
    e.fc = m_fc;
    return e;
  endfunction

  task automatic step(input logic e_in);
    logic fs;
    fs = 1'b0;
    en = e_in;
    if (e_in) begin
      if (m_h == HT - 1) begin
        m_h = 0;
        if (m_v == VT - 1) begin
          m_v = 0;
          m_fc = m_fc + 16'd1;
          fs = 1'b1;
        end else m_v++;
      end else m_h++;
    end
    sb.push_back(model_out(fs));
    @(posedge clk);
    #3;
  endtask

  task automatic test_reset;
    rst = 1'b0; en = 1'b1;
    m_h = 0; m_v = 0; m_fc = '0;
    repeat (3) @(posedge clk);
    #3;
    total++;
    if (obs !== '0) begin
      bad++; $display("FAIL reset_hold: got %h want 0", obs);
    end
    rst = 1'b1;
    repeat (5) step(1'b1);
    total++;
    if (hcount_out !== 11'd5 || vcount_out !== 11'd0 || hblnk_out !== 1'b0 || vblnk_out !== 1'b0) begin
      bad++; $display("FAIL reset_5clk: got h=%0d v=%0d hb=%b vb=%b want 5 0 0 0",
                      hcount_out, vcount_out, hblnk_out, vblnk_out);
    end
  endtask

  task automatic test_hline;
    int n_hb = 0, n_hs = 0, first_hs = -1;
    for (int i = 0; i < HT; i++) begin
      step(1'b1);
      if (vcount_out == 11'd0) begin
        if (hblnk_out) n_hb++;
        if (hsync_out) begin
          n_hs++;
          if (first_hs < 0) first_hs = int'(hcount_out);
        end
      end
      if (m_h == 0) break;
    end
    total++;
    if (n_hb != HT - HA) begin bad++; $display("FAIL hblnk_len: got %0d want %0d", n_hb, HT - HA); end
    total++;
    if (n_hs != HS) begin bad++; $display("FAIL hsync_len: got %0d want %0d", n_hs, HS); end
    total++;
    if (first_hs != HA + HFP) begin bad++; $display("FAIL hsync_start: got %0d want %0d", first_hs, HA + HFP); end
    total++;
    if (hcount_out !== 11'd0 || vcount_out !== 11'd1 || hblnk_out !== 1'b0) begin
      bad++; $display("FAIL line_wrap: got h=%0d v=%0d hb=%b want 0 1 0", hcount_out, vcount_out, hblnk_out);
    end
  endtask

  task automatic test_frame;
    int n_fs = 0, n_vs = 0, n_vb = 0, first_vs = -1, last_vs = -1;
    for (int i = 0; i < HT * VT + 5; i++) begin
      step(1'b1);
      if (frame_start) n_fs++;
      if (vblnk_out) n_vb++;
      if (vsync_out) begin
        n_vs++;
        if (first_vs < 0) first_vs = int'(vcount_out);
        last_vs = int'(vcount_out);
      end
      if (m_h == 0 && m_v == 0) break;
    end
    total++;
    if (n_fs != 1) begin bad++; $display("FAIL frame_pulses: got %0d want 1", n_fs); end
    total++;
    if (frame_cnt !== 16'd1 || frame_start !== 1'b1) begin
      bad++; $display("FAIL frame_cnt: got cnt=%0d fs=%b want 1 1", frame_cnt, frame_start);
    end
    total++;
    if (n_vs != VS * HT || first_vs != VA + VFP || last_vs != VA + VFP + VS - 1) begin
      bad++; $display("FAIL vsync_span: got n=%0d lines %0d..%0d want %0d lines %0d..%0d",
                      n_vs, first_vs, last_vs, VS * HT, VA + VFP, VA + VFP + VS - 1);
    end
    total++;
    if (n_vb != (VT - VA) * HT) begin bad++; $display("FAIL vblnk_len: got %0d want %0d", n_vb, (VT - VA) * HT); end
    total++;
    if (hcount_out !== 11'd0 || vcount_out !== 11'd0) begin
      bad++; $display("FAIL frame_origin: got h=%0d v=%0d want 0 0", hcount_out, vcount_out);
    end
  endtask

  task automatic test_enable_hold;
    int n_fs = 0;
    for (int i = 0; i < HT * VT + 5; i++) begin
      if (m_h == HT - 1 && m_v == VT - 1) break;
      step(1'b1);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      if (frame_start) n_fs++;
    end
    total++;
    if (n_fs != 0 || hcount_out !== 11'(HT - 1) || vcount_out !== 11'(VT - 1)) begin
      bad++; $display("FAIL en_hold: got fs=%0d h=%0d v=%0d want 0 %0d %0d", n_fs, hcount_out, vcount_out, HT - 1, VT - 1);
    end
    step(1'b1);
    total++;
    if (frame_start !== 1'b1 || frame_cnt !== 16'd2 || hcount_out !== 11'd0) begin
      bad++; $display("FAIL en_wrap: got fs=%b cnt=%0d h=%0d want 1 2 0", frame_start, frame_cnt, hcount_out);
    end
    step(1'b0);
    step(1'b1);
    total++;
    if (frame_start !== 1'b0) begin bad++; $display("FAIL en_toggle: got fs=%b want 0", frame_start); end
  endtask

  task automatic test_cnt_wrap;
    logic got_fs;
    step(1'b0);
    force dut.frame_cnt = 16'hFFFF;
    m_fc = 16'hFFFF;
    step(1'b0);
    release dut.frame_cnt;
    step(1'b0);
    total++;
    if (frame_cnt !== 16'hFFFF) begin bad++; $display("FAIL preload: got %h want ffff", frame_cnt); end
    got_fs = 1'b0;
    for (int i = 0; i < HT * VT + 5; i++) begin
      step(1'b1);
      if (m_h == 0 && m_v == 0) begin got_fs = frame_start; break; end
    end
    total++;
    if (frame_cnt !== 16'h0000 || got_fs !== 1'b1) begin
      bad++; $display("FAIL cnt_wrap: got cnt=%h fs=%b want 0000 1", frame_cnt, got_fs);
    end
  endtask

  task automatic test_async_reset;
    logic seen_fs;
    for (int i = 0; i < HT * VT + 5; i++) begin
      if (m_h == 10 && m_v == 4) break;
      step(1'b1);
    end
    rst = 1'b0;
    #1;
    total++;
    if (obs !== '0) begin bad++; $display("FAIL async_reset: got %h want 0", obs); end
    m_h = 0; m_v = 0; m_fc = '0;
    seen_fs = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (frame_start || frame_cnt != 16'd0) seen_fs = 1'b1;
    end
    total++;
    if (seen_fs !== 1'b0) begin bad++; $display("FAIL reset_quiet: got 1 want 0"); end
    #2;
    rst = 1'b1;
    step(1'b1);
    total++;
    if (hcount_out !== 11'd1 || vcount_out !== 11'd0 || frame_start !== 1'b0) begin
      bad++; $display("FAIL post_reset: got h=%0d v=%0d fs=%b want 1 0 0", hcount_out, vcount_out, frame_start);
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0;
    m_h = 0; m_v = 0; m_fc = '0;
    test_reset();
    test_hline();
    test_frame();
    test_enable_hold();
    test_cnt_wrap();
    test_async_reset();
    @(posedge clk); #3;
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL sb_drain: got %0d want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
